seq_detect_prog: RTL and testbench

- Parameterised, runtime-programmable serial bit-pattern detector. It is the general successor to the fixed 4-bit Mealy detector.
- Compares the most recent LEN valid input bits against a programmable pattern of up to MAX_LEN bits.
- Supports overlapping and non-overlapping modes.
- Produces a same-cycle Mealy match pulse, a saturating match counter and a sticky overflow flag.
- Sits at the front of serial-protocol framing and sync-word detection logic.

---
 rtl/seq_detect_prog.sv | 108 ++++++++++
 tb/tb_seq_detect_prog.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector.
// Mealy match pulse, saturating match counter and sticky overflow.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 16,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 16'h000D,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LW          = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow,
  output logic [LW-1:0]      busy_fill
);

  localparam logic [MAX_LEN:0] ONE    = 1;
  localparam logic [LW-1:0]    LMAX   = LW'(MAX_LEN);

  // The oldest history bit can never be part of a compare, since the
  // incoming din always occupies the lowest window position.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN:0]   one_sh;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;

  assign accept  = din_valid & ~cfg_we & ~clr;
  assign cand    = {hist_q, din};
  assign one_sh  = ONE << len_q;
  assign mask    = MAX_LEN'(one_sh - ONE);
  assign fill_ok = fill_q >= (len_q - LW'(1));

  assign match = accept & (len_q != '0) & fill_ok
               & ((cand & mask) == (pat_q & mask));

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (accept) begin
      hist_d = cand[MAX_LEN-2:0];
      if (fill_q != LMAX) fill_d = fill_q + LW'(1);
    end
    if (match) begin
      if (!ovl_q) fill_d = '0;
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
    if (cfg_we) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > LMAX) ? LMAX : cfg_len;
      ovl_d  = cfg_overlap;
      fill_d = '0;
    end
    if (clr) begin
      fill_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LW'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign match_count = cnt_q;
  assign overflow    = ovf_q;
  assign busy_fill   = fill_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed-vector bench for seq_detect_prog.
// Small CNT_W so counter saturation is reachable.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN+1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clr = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               overflow;
  logic [LW-1:0]      busy_fill;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_detect_prog #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .din_valid  (din_valid),
    .din        (din),
    .match      (match),
    .match_count(match_count),
    .overflow   (overflow),
    .busy_fill  (busy_fill)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // one cycle: drive at negedge, check Mealy output before the edge
  task automatic step(input logic v, input logic d, input logic c,
                      input logic em, input string tag);
    @(negedge clk);
    din_valid = v;
    din       = d;
    clr       = c;
    #1 chk(tag, {31'd0, match}, {31'd0, em});
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l,
                     input logic o, input logic c, input logic v,
                     input logic d);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    clr         = c;
    din_valid   = v;
    din         = d;
    #1 chk("cfg_match", {31'd0, match}, 32'd0);
    @(posedge clk);
    #1;
    cfg_we    = 1'b0;
    clr       = 1'b0;
    din_valid = 1'b0;
  endtask

  logic [6:0]  s7;
  logic [6:0]  m7;
  logic [4:0]  s5;
  logic [4:0]  m5;
  logic [15:0] pw;
  logic [1:0]  cexp [5];
  logic        oexp [5];

  initial begin
    #12 rst = 1'b0;
    #1;
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_cnt", 32'(match_count), 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_fill", 32'(busy_fill), 32'd0);

    // default 1101, overlapping
    s7 = 7'b1101101;
    m7 = 7'b0001001;
    for (int i = 0; i < 7; i++)
      step(1'b1, s7[6-i], 1'b0, m7[6-i], "def_match");
    chk("def_cnt", 32'(match_count), 32'd2);
    chk("def_fill", 32'(busy_fill), 32'd7);
    step(1'b0, 1'b0, 1'b1, 1'b0, "clr_match");
    chk("clr_cnt", 32'(match_count), 32'd0);

    // 101 non-overlapping
    cfg(16'h0005, LW'(3), 1'b0, 1'b0, 1'b0, 1'b0);
    s5 = 5'b10101;
    m5 = 5'b00100;
    for (int i = 0; i < 5; i++)
      step(1'b1, s5[4-i], 1'b0, m5[4-i], "nov_match");
    chk("nov_cnt", 32'(match_count), 32'd1);

    // 101 overlapping, counter cleared alongside
    cfg(16'h0005, LW'(3), 1'b1, 1'b1, 1'b0, 1'b0);
    m5 = 5'b00101;
    for (int i = 0; i < 5; i++)
      step(1'b1, s5[4-i], 1'b0, m5[4-i], "ov_match");
    chk("ov_cnt", 32'(match_count), 32'd2);

    // 1101 with a 3-cycle valid gap before the last bit
    cfg(16'h000D, LW'(4), 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap_b1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap_b2");
    step(1'b1, 1'b0, 1'b0, 1'b0, "gap_b3");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, "gap_idle");
    chk("gap_fill", 32'(busy_fill), 32'd3);
    step(1'b1, 1'b1, 1'b0, 1'b1, "gap_b4");
    chk("gap_cnt", 32'(match_count), 32'd1);

    // len 1, counter saturation and overflow
    cexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    oexp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    cfg(16'h0001, LW'(1), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, "sat_match");
      chk("sat_cnt", 32'(match_count), 32'(cexp[i]));
      chk("sat_ovf", {31'd0, overflow}, {31'd0, oexp[i]});
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, "clr_bit");
    chk("clr_cnt2", 32'(match_count), 32'd0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, "len1_zero");

    // len 0 disables, fill keeps tracking
    cfg(16'h0000, LW'(0), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, "len0_a");
    step(1'b1, 1'b0, 1'b0, 1'b0, "len0_b");
    chk("len0_fill", 32'(busy_fill), 32'd2);

    // len 31 clamps to 16
    pw = 16'hA5C3;
    cfg(pw, LW'(31), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      step(1'b1, pw[15-i], 1'b0, (i == 15), "clamp_match");
    chk("clamp_fill", 32'(busy_fill), 32'd16);
    step(1'b1, 1'b0, 1'b0, 1'b0, "clamp_x1");
    step(1'b1, 1'b0, 1'b0, 1'b0, "clamp_x2");
    chk("fill_sat", 32'(busy_fill), 32'd16);

    // cfg_we discards same-cycle bit and empties history
    cfg(16'h000D, LW'(4), 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "cw_b1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "cw_b2");
    step(1'b1, 1'b0, 1'b0, 1'b0, "cw_b3");
    cfg(16'h000D, LW'(4), 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, "cw_b4");
    chk("cw_fill", 32'(busy_fill), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, "cw_r1");
    step(1'b1, 1'b0, 1'b0, 1'b0, "cw_r2");
    step(1'b1, 1'b1, 1'b0, 1'b1, "cw_r3");
    chk("cw_cnt", 32'(match_count), 32'd1);

    // async reset restores the default pattern
    cfg(16'h0007, LW'(3), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "ar_b1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "ar_b2");
    step(1'b1, 1'b0, 1'b0, 1'b0, "ar_b3");
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("ar_cnt", 32'(match_count), 32'd0);
    chk("ar_fill", 32'(busy_fill), 32'd0);
    chk("ar_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, "ar_b4");
    chk("ar_cnt2", 32'(match_count), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "ar_f1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "ar_f2");
    step(1'b1, 1'b0, 1'b0, 1'b0, "ar_f3");
    step(1'b1, 1'b1, 1'b0, 1'b1, "ar_f4");
    chk("ar_cnt3", 32'(match_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
